// File: rtl/vga_frame_scanner_if.sv
// Scan-out bus: framebuffer read port plus the colour/sync outputs toward the DAC.
interface vga_frame_scanner_if;
  logic [31:0] vga_pixel_addr;
  logic [7:0]  vga_pixel_val;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_blank_n;
  logic        vga_sync_n;
  logic        frame_start;

  modport master (
    output vga_pixel_addr, vga_r, vga_g, vga_b,
    output vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start,
    input  vga_pixel_val
  );

  modport slave (
    input  vga_pixel_addr, vga_r, vga_g, vga_b,
    input  vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start,
    output vga_pixel_val
  );
endinterface

// File: rtl/vga_frame_scanner.sv
// VGA scan-out: raster counters, framebuffer address generation and RGB332 expansion
// with sync/blank delayed to match the 3-cycle memory/data pipeline.
module vga_frame_scanner #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned IMG_W    = 100,
  parameter int unsigned IMG_H    = 100,
  parameter int unsigned SCALE    = 0,
  parameter int unsigned BASE     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_frame_scanner_if.master  bus
);

  localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOT);
  localparam int unsigned VW       = $clog2(V_TOT);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  // Timing flag bundle carried down the pipeline: {fs, vs_n, hs_n, in_img, active}
  localparam int unsigned FW    = 5;
  localparam int unsigned F_ACT = 0;
  localparam int unsigned F_IMG = 1;
  localparam int unsigned F_HS  = 2;
  localparam int unsigned F_VS  = 3;
  localparam int unsigned F_FS  = 4;
  localparam logic [FW-1:0] FLAGS_IDLE = 5'b01100;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   addr_q, addr_d;
  logic [FW-1:0] f1_q, f1_d;
  logic [FW-1:0] f2_q, f2_d;
  logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          blank_n_q, blank_n_d, fs_q, fs_d;

  logic [HW-1:0] ix;
  logic [VW-1:0] iy;
  logic          act, in_img, hs_n, vs_n, fs;
  logic [7:0]    p;

  // S0: raster counters
  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (32'(h_q) == H_TOT - 1) begin
      h_d = '0;
      if (32'(v_q) == V_TOT - 1) v_d = '0;
      else                       v_d = v_q + VW'(1);
    end
  end

  // S0 decode feeding S1: address and timing flags
  always_comb begin
    ix     = h_q >> SCALE;
    iy     = v_q >> SCALE;
    act    = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    in_img = act && (32'(ix) < IMG_W) && (32'(iy) < IMG_H);
    hs_n   = !((32'(h_q) >= HS_START) && (32'(h_q) < HS_END));
    vs_n   = !((32'(v_q) >= VS_START) && (32'(v_q) < VS_END));
    fs     = (h_q == '0) && (v_q == '0);
    addr_d = BASE;
    if (in_img) addr_d = BASE + 32'(iy) * IMG_W + 32'(ix);
    f1_d   = {fs, vs_n, hs_n, in_img, act};
    f2_d   = f1_q;
  end

  // S3: colour expansion by bit replication so full-scale codes reach 0xFF
  always_comb begin
    p         = bus.vga_pixel_val;
    r_d       = '0;
    g_d       = '0;
    b_d       = '0;
    if (f2_q[F_IMG]) begin
      r_d = {p[7:5], p[7:5], p[7:6]};
      g_d = {p[4:2], p[4:2], p[4:3]};
      b_d = {p[1:0], p[1:0], p[1:0], p[1:0]};
    end
    hsync_d   = f2_q[F_HS];
    vsync_d   = f2_q[F_VS];
    blank_n_d = f2_q[F_ACT];
    fs_d      = f2_q[F_FS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q       <= '0;
      v_q       <= '0;
      addr_q    <= BASE;
      f1_q      <= FLAGS_IDLE;
      f2_q      <= FLAGS_IDLE;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      addr_q    <= addr_d;
      f1_q      <= f1_d;
      f2_q      <= f2_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      blank_n_q <= blank_n_d;
      fs_q      <= fs_d;
    end
  end

  assign bus.vga_pixel_addr = addr_q;
  assign bus.vga_r          = r_q;
  assign bus.vga_g          = g_q;
  assign bus.vga_b          = b_q;
  assign bus.vga_hsync      = hsync_q;
  assign bus.vga_vsync      = vsync_q;
  assign bus.vga_blank_n    = blank_n_q;
  assign bus.vga_sync_n     = 1'b0;
  assign bus.frame_start    = fs_q;

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Scoreboard bench: three scanner configurations (full VGA, small, scaled) run against
// a raster-position reference model with random mid-frame resets.
module tb_vga_frame_scanner;

  localparam int NCFG = 3;
  localparam int unsigned C_HA[NCFG]   = '{640, 40, 24};
  localparam int unsigned C_HF[NCFG]   = '{16, 4, 3};
  localparam int unsigned C_HS[NCFG]   = '{96, 8, 5};
  localparam int unsigned C_HB[NCFG]   = '{48, 6, 4};
  localparam int unsigned C_VA[NCFG]   = '{480, 30, 20};
  localparam int unsigned C_VF[NCFG]   = '{10, 2, 2};
  localparam int unsigned C_VS[NCFG]   = '{2, 2, 2};
  localparam int unsigned C_VB[NCFG]   = '{33, 3, 2};
  localparam int unsigned C_W[NCFG]    = '{100, 20, 10};
  localparam int unsigned C_H[NCFG]    = '{100, 12, 8};
  localparam int unsigned C_SC[NCFG]   = '{0, 0, 1};
  localparam int unsigned C_BASE[NCFG] = '{0, 100, 2000};
  localparam int MAX_ERR = 50;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        bn;
    logic        sn;
    logic        fs;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tbl [4096];
  obs_t       obs [NCFG];
  obs_t       exp_q [$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return tbl[a[11:0]];
  endfunction

  generate
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
      vga_frame_scanner_if ifc ();
      vga_frame_scanner #(
        .H_ACTIVE(C_HA[g]), .H_FP(C_HF[g]), .H_SYNC(C_HS[g]), .H_BP(C_HB[g]),
        .V_ACTIVE(C_VA[g]), .V_FP(C_VF[g]), .V_SYNC(C_VS[g]), .V_BP(C_VB[g]),
        .IMG_W(C_W[g]), .IMG_H(C_H[g]), .SCALE(C_SC[g]), .BASE(C_BASE[g])
      ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
      );
      // Framebuffer with one cycle of read latency
      always @(posedge clk) ifc.vga_pixel_val <= mem_rd(ifc.vga_pixel_addr);
      assign obs[g] = {ifc.vga_pixel_addr, ifc.vga_r, ifc.vga_g, ifc.vga_b, ifc.vga_hsync,
                       ifc.vga_vsync, ifc.vga_blank_n, ifc.vga_sync_n, ifc.frame_start};
    end
  endgenerate

  function automatic logic [7:0] scale3(input int v);
    return 8'((v * 255 + 3) / 7);
  endfunction

  // What a screen position k (counted in raster order from frame origin) should produce
  function automatic obs_t at_pos(input int c, input int k);
    obs_t e;
    int ht, vt, p, h, v, ix, iy;
    bit act, inimg;
    logic [7:0] px;
    ht = int'(C_HA[c] + C_HF[c] + C_HS[c] + C_HB[c]);
    vt = int'(C_VA[c] + C_VF[c] + C_VS[c] + C_VB[c]);
    p  = k % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    act   = (h < int'(C_VA[c] * 0 + C_HA[c])) && (v < int'(C_VA[c]));
    ix    = h / (1 << C_SC[c]);
    iy    = v / (1 << C_SC[c]);
    inimg = act && (ix < int'(C_W[c])) && (iy < int'(C_H[c]));
    e = '0;
    e.addr = inimg ? C_BASE[c] + 32'(iy) * C_W[c] + 32'(ix) : C_BASE[c];
    px = mem_rd(e.addr);
    if (inimg) begin
      e.r = scale3(int'(px[7:5]));
      e.g = scale3(int'(px[4:2]));
      e.b = 8'(int'(px[1:0]) * 85);
    end
    e.hs = !((h >= int'(C_HA[c] + C_HF[c])) && (h < int'(C_HA[c] + C_HF[c] + C_HS[c])));
    e.vs = !((v >= int'(C_VA[c] + C_VF[c])) && (v < int'(C_VA[c] + C_VF[c] + C_VS[c])));
    e.bn = act;
    e.sn = 1'b0;
    e.fs = (h == 0) && (v == 0);
    return e;
  endfunction

  // Expected pins after an edge: cnt = run edges since the last reset edge
  function automatic obs_t model(input int c, input bit rst, input int cnt);
    obs_t e, a, o;
    e = '0;
    e.addr = C_BASE[c];
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (!rst) begin
      a = at_pos(c, cnt - 1);
      e.addr = a.addr;
      if (cnt - 1 >= 2) begin
        o = at_pos(c, cnt - 3);
        e = o;
        e.addr = a.addr;
      end
    end
    return e;
  endfunction

  // Stimulus side of the scoreboard: push expectations every edge
  initial begin
    int cnt;
    bit rs;
    cnt = 0;
    forever begin
      @(posedge clk);
      rs = reset;
      if (rs) cnt = 0;
      else cnt++;
      for (int c = 0; c < NCFG; c++) exp_q.push_back(model(c, rs, cnt));
    end
  end

  // Monitor: pop and compare just after each edge
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL queue_empty cfg%0d cyc%0d", c, cyc);
        end else begin
          e = exp_q.pop_front();
          if (obs[c] !== e) begin
            errors++;
            $display("FAIL pins cfg%0d cyc%0d got addr=%0d rgb=%h%h%h hs/vs/bn/sn/fs=%b%b%b%b%b exp addr=%0d rgb=%h%h%h hs/vs/bn/sn/fs=%b%b%b%b%b",
                     c, cyc, obs[c].addr, obs[c].r, obs[c].g, obs[c].b, obs[c].hs, obs[c].vs,
                     obs[c].bn, obs[c].sn, obs[c].fs, e.addr, e.r, e.g, e.b, e.hs, e.vs, e.bn,
                     e.sn, e.fs);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4096; i++) tbl[i] = 8'($urandom);
    tbl[5] = 8'h1C;    tbl[6] = 8'hFF;
    tbl[105] = 8'h1C;  tbl[106] = 8'hFF;
    tbl[2005] = 8'h1C; tbl[2006] = 8'hFF;
    tbl[294] = 8'hA5;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2500 && errors < MAX_ERR; i++) @(negedge clk);
    for (int n = 0; n < 12 && errors < MAX_ERR; n++) begin
      repeat ($urandom_range(300, 2500)) @(negedge clk);
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      reset = 1'b0;
    end
    for (int i = 0; i < 6000 && errors < MAX_ERR; i++) @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
